// File: rtl/mem_bus_if.sv
// Downstream memory port shared by the fetch and memory stages.
// The arbiter drives the request side; the memory drives read data and the ack strobe.
interface mem_bus_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  logic              bus_req_o;
  logic              bus_we_o;
  logic [SEL_W-1:0]  bus_sel_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_data_o;
  logic [DATA_W-1:0] bus_data_i;
  logic              bus_ack_i;

  modport master (
    output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o,
    input  bus_data_i, bus_ack_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o,
    output bus_data_i, bus_ack_i
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority (data over fetch) arbiter for a single downstream memory port.
// In-flight transfers always run to ack; a flush only discards the returned result.
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ce_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_data_o,
  output logic        inst_stallreq_o,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_sel_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_data_i,
  output logic [31:0] data_data_o,
  output logic        data_stallreq_o,
  input  logic        stall_i,
  input  logic        flush_i,
  mem_bus_if.master   bus
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2
  } state_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } bus_cmd_t;

  state_t            state_q, state_d;
  bus_cmd_t          cmd_q, cmd_d;
  logic              discard_q, discard_d;
  logic              inst_done_q, inst_done_d;
  logic              data_done_q, data_done_d;
  logic [DATA_W-1:0] inst_data_q, inst_data_d;
  logic [DATA_W-1:0] data_rd_q, data_rd_d;
  logic              inst_pend, data_pend;
  logic              set_idone, set_ddone;

  assign inst_pend = inst_ce_i & ~inst_done_q;
  assign data_pend = data_ce_i & ~data_done_q;

  // State register, latched request and captured read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      discard_q   <= 1'b0;
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
      inst_data_q <= '0;
      data_rd_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      discard_q   <= discard_d;
      inst_done_q <= inst_done_d;
      data_done_q <= data_done_d;
      inst_data_q <= inst_data_d;
      data_rd_q   <= data_rd_d;
    end
  end

  // Next-state: grant, hold until ack, capture or discard the result
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    discard_d   = discard_q;
    inst_data_d = inst_data_q;
    data_rd_d   = data_rd_q;
    set_idone   = 1'b0;
    set_ddone   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!flush_i) begin
          if (data_pend) begin
            state_d    = D_BUSY;
            cmd_d.req  = 1'b1;
            cmd_d.we   = data_we_i;
            cmd_d.sel  = data_sel_i;
            cmd_d.addr = data_addr_i;
            cmd_d.data = data_data_i;
          end else if (inst_pend) begin
            state_d    = I_BUSY;
            cmd_d.req  = 1'b1;
            cmd_d.we   = 1'b0;
            cmd_d.sel  = {SEL_W{1'b1}};
            cmd_d.addr = inst_addr_i;
            cmd_d.data = '0;
          end
        end
      end
      D_BUSY, I_BUSY: begin
        if (flush_i) discard_d = 1'b1;
        if (bus.bus_ack_i) begin
          state_d   = IDLE;
          cmd_d     = '0;
          discard_d = 1'b0;
          // A flush now or earlier in this transfer drops the result
          if (!discard_q && !flush_i) begin
            if (state_q == D_BUSY) begin
              set_ddone = 1'b1;
              if (!cmd_q.we) data_rd_d = bus.bus_data_i;
            end else begin
              set_idone   = 1'b1;
              inst_data_d = bus.bus_data_i;
            end
          end
        end
      end
      default: begin
        state_d   = IDLE;
        cmd_d     = '0;
        discard_d = 1'b0;
      end
    endcase

    // Completion wins over the pipeline-advance clear in the same cycle
    inst_done_d = set_idone | (inst_done_q & stall_i & ~flush_i);
    data_done_d = set_ddone | (data_done_q & stall_i & ~flush_i);
  end

  assign inst_stallreq_o = inst_ce_i & ~inst_done_q & ~flush_i;
  assign data_stallreq_o = data_ce_i & ~data_done_q & ~flush_i;
  assign inst_data_o     = inst_data_q;
  assign data_data_o     = data_rd_q;

  assign bus.bus_req_o  = cmd_q.req;
  assign bus.bus_we_o   = cmd_q.we;
  assign bus.bus_sel_o  = cmd_q.sel;
  assign bus.bus_addr_o = cmd_q.addr;
  assign bus.bus_data_o = cmd_q.data;

endmodule
